pipe_add: RTL and testbench

- Parametrised, pipelined ripple-carry adder/subtractor with valid/ready handshake. Generalises the single-bit full-adder cell to WIDTH bits split across STAGES register stages.
- Used in the Sobel datapath to sum and difference gradient partial terms (Gx/Gy accumulation) at full clock rate.
- Stalls cleanly under downstream backpressure.

---
 rtl/sobel_pkg.sv | 20 ++
 rtl/add_chunk.sv | 31 +++
 rtl/pipe_add.sv | 135 +++++++++++++
 tb/tb_pipe_add.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel datapath arithmetic blocks.
//   op_e    : operation select for pipe_add (add / subtract)
//   chunk_w : bits resolved per pipeline stage for a WIDTH/STAGES split
package sobel_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // An illegal stage count is rejected by the instantiating module;
    // the guard here only keeps the division defined during elaboration.
    function automatic int chunk_w(input int width, input int stages);
        if (stages < 1) begin
            return width;
        end
        return width / stages;
    endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational W-bit ripple of full-adder cells.
//   a_i, b_i : operand chunk
//   c_i      : carry into bit 0 of the chunk
//   sum_o    : chunk sum bits
//   cout_o   : carry out of the chunk MSB
//   cmsb_o   : carry into the chunk MSB (for signed overflow on the top chunk)
module add_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o,
    output logic         cmsb_o
);

    logic [W:0] cy;

    always_comb begin
        cy[0] = c_i;
        for (int i = 0; i < W; i++) begin
            sum_o[i]  = a_i[i] ^ b_i[i] ^ cy[i];
            cy[i + 1] = ((a_i[i] ^ b_i[i]) & cy[i]) | (a_i[i] & b_i[i]);
        end
    end

    assign cout_o = cy[W];
    assign cmsb_o = cy[W - 1];

endmodule

// File: rtl/pipe_add.sv
// Pipelined ripple-carry adder/subtractor with valid/ready handshake.
// Stage k resolves bits [k*C +: C] (C = WIDTH/STAGES) using the carry
// registered by stage k-1; operand bits not yet consumed and sum bits
// already produced travel alongside in skew registers.
//   clk_i, rst_ni     : clock, async active-low reset
//   valid_i / ready_o : input handshake (a_i, b_i, sub_i)
//   valid_o / ready_i : output handshake (sum_o, carry_o, ovf_o)
//   carry_o           : carry out of MSB (sub: 1 = no borrow)
//   ovf_o             : two's-complement overflow
module pipe_add
    import sobel_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             ovf_o
);

    localparam int C = chunk_w(WIDTH, STAGES);

    if ((STAGES < 1) || (STAGES > WIDTH) ||
        ((WIDTH % ((STAGES < 1) ? 1 : STAGES)) != 0)) begin : g_bad_cfg
        $fatal(1, "pipe_add: WIDTH must be a multiple of STAGES (1..WIDTH)");
    end

    op_e              op;
    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             cm_q;

    // Subtract as A + ~B + 1; the +1 enters as the stage-0 carry.
    assign op      = op_e'(sub_i);
    assign b_eff   = (op == OP_SUB) ? ~b_i : b_i;
    // One global enable: the whole pipe freezes while a result is refused.
    assign advance = ~valid_o | ready_i;
    assign ready_o = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int SW = WIDTH - k * C;  // operand bits still unconsumed on entry

        logic [SW-1:0]        a_src;
        logic [SW-1:0]        b_src;
        logic                 cin;
        logic                 v_d;
        logic [C-1:0]         s_c;
        logic                 c_d;
        logic                 cm;
        logic [(k+1)*C-1:0]   s_d;
        logic                 v_q;
        logic                 c_q;
        logic [(k+1)*C-1:0]   s_q;

        if (k == 0) begin : g_src
            assign a_src = a_i;
            assign b_src = b_eff;
            assign cin   = (op == OP_SUB);
            assign v_d   = valid_i;
            assign s_d   = s_c;
        end else begin : g_src
            assign a_src = g_st[k-1].g_ops.a_q;
            assign b_src = g_st[k-1].g_ops.b_q;
            assign cin   = g_st[k-1].c_q;
            assign v_d   = g_st[k-1].v_q;
            assign s_d   = {s_c, g_st[k-1].s_q};
        end

        add_chunk #(
            .W (C)
        ) u_chunk (
            .a_i    (a_src[C-1:0]),
            .b_i    (b_src[C-1:0]),
            .c_i    (cin),
            .sum_o  (s_c),
            .cout_o (c_d),
            .cmsb_o (cm)
        );

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (advance) begin
                v_q <= v_d;
                c_q <= c_d;
                s_q <= s_d;
            end
        end

        // Every stage but the last forwards the operand bits it did not use.
        if (k < STAGES - 1) begin : g_ops
            logic [SW-C-1:0] a_q;
            logic [SW-C-1:0] b_q;
            logic            cm_unused;

            // Carry into the chunk MSB only matters for the top chunk.
            assign cm_unused = cm;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_src[SW-1:C];
                    b_q <= b_src[SW-1:C];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cm_q <= 1'b0;
        end else if (advance) begin
            cm_q <= g_st[STAGES-1].cm;
        end
    end

    assign valid_o = g_st[STAGES-1].v_q;
    assign sum_o   = g_st[STAGES-1].s_q;
    assign carry_o = g_st[STAGES-1].c_q;
    assign ovf_o   = g_st[STAGES-1].c_q ^ cm_q;

endmodule

// File: tb/tb_pipe_add.sv
// Bench for pipe_add: six configurations share one stimulus stream, each
// with its own scoreboard fed by an arithmetic a+/-b reference.
module tb_pipe_add;

    localparam int NI = 6;

    function automatic int w_of(input int g);
        case (g)
            0:       return 4;
            1:       return 8;
            default: return 16;
        endcase
    endfunction

    function automatic int s_of(input int g);
        case (g)
            0, 1, 2: return 2;
            3:       return 1;
            4:       return 4;
            default: return 16;
        endcase
    endfunction

    typedef struct {
        logic [17:0] r;
        int          cyc;
    } ent_t;

    logic              clk;
    logic              rst_n;
    logic              valid_i;
    logic              ready_i;
    logic              sub_i;
    logic [15:0]       a_drv;
    logic [15:0]       b_drv;
    logic              lat_chk;
    int                cycle = 0;
    int                n_chk = 0;
    int                n_bad = 0;
    logic [NI-1:0]     vo_all;
    logic [NI-1:0]     rdy_all;
    logic [NI-1:0]     pend_all;
    logic [NI-1:0][17:0] res_all;

    // Reference result packed as {ovf, carry, sum[15:0]}.
    function automatic logic [17:0] ref_res(input int w, input logic [15:0] a,
                                            input logic [15:0] b, input logic s);
        longint m, av, bv, half, sa, sb, r, sr;
        logic   c, o;
        m    = (longint'(1) << w) - 1;
        av   = longint'(a) & m;
        bv   = longint'(b) & m;
        half = longint'(1) << (w - 1);
        sa   = (av >= half) ? av - 2 * half : av;
        sb   = (bv >= half) ? bv - 2 * half : bv;
        r    = s ? av - bv : av + bv;
        sr   = s ? sa - sb : sa + sb;
        c    = s ? (av >= bv) : (r > m);
        o    = (sr >= half) || (sr < -half);
        return {o, c, 16'(r & m)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cycle++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int W = w_of(g);
        localparam int S = s_of(g);

        logic         ready_o, valid_o, carry_o, ovf_o;
        logic [W-1:0] sum_o;
        logic [17:0]  res;
        ent_t         q[$];
        ent_t         e;
        logic         hold_q;
        logic [17:0]  held;
        int           npend;

        pipe_add #(
            .WIDTH  (W),
            .STAGES (S)
        ) u_dut (
            .clk_i   (clk),
            .rst_ni  (rst_n),
            .valid_i (valid_i),
            .ready_o (ready_o),
            .a_i     (a_drv[W-1:0]),
            .b_i     (b_drv[W-1:0]),
            .sub_i   (sub_i),
            .valid_o (valid_o),
            .ready_i (ready_i),
            .sum_o   (sum_o),
            .carry_o (carry_o),
            .ovf_o   (ovf_o)
        );

        assign res         = {ovf_o, carry_o, 16'(sum_o)};
        assign vo_all[g]   = valid_o;
        assign rdy_all[g]  = ready_o;
        assign res_all[g]  = res;
        assign pend_all[g] = (npend != 0);

        initial begin
            hold_q = 1'b0;
            held   = '0;
            npend  = 0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    q.delete();
                    hold_q = 1'b0;
                end else begin
                    if (hold_q) begin
                        chk("hold_valid", 32'(valid_o), 32'd1);
                        chk("hold_data", 32'(res), 32'(held));
                    end
                    if (valid_o && !ready_i) begin
                        chk("stall_ready", 32'(ready_o), 32'd0);
                    end
                    if (valid_o && ready_i) begin
                        if (q.size() == 0) begin
                            chk("unexpected_valid", 32'(valid_o), 32'd0);
                        end else begin
                            e = q.pop_front();
                            chk("result", 32'(res), 32'(e.r));
                            if (lat_chk) begin
                                chk("latency", 32'(cycle - e.cyc), 32'(S));
                            end
                        end
                    end
                    if (valid_i && ready_o) begin
                        q.push_back('{r: ref_res(W, a_drv, b_drv, sub_i), cyc: cycle});
                    end
                    hold_q = valid_o && !ready_i;
                    held   = res;
                end
                npend = q.size();
            end
        end
    end

    task automatic rand_op();
        logic [31:0] r1, r2;
        r1    = $urandom();
        r2    = $urandom();
        a_drv = r1[15:0];
        b_drv = r1[31:16];
        sub_i = r2[0];
    endtask

    // Called at posedge+1; returns at posedge+1 with every pipe empty.
    task automatic drain();
        int n;
        n       = 0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        while (pend_all != '0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(pend_all), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // One isolated op; each configuration must present it exactly S cycles later.
    task automatic send_one(input logic [15:0] a, input logic [15:0] b,
                            input logic s, input logic [17:0] exp8);
        valid_i = 1'b1;
        a_drv   = a;
        b_drv   = b;
        sub_i   = s;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            for (int g = 0; g < NI; g++) begin
                if (s_of(g) == n) begin
                    chk("direct_valid", 32'(vo_all[g]), 32'd1);
                    chk("direct_result", 32'(res_all[g]), 32'(ref_res(w_of(g), a, b, s)));
                    if (g == 1) begin
                        chk("w8_literal", 32'(res_all[g]), 32'(exp8));
                    end
                end else if (s_of(g) > n) begin
                    chk("early_valid", 32'(vo_all[g]), 32'd0);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          n_acc;
        int          guard;
        logic        acc;
        logic [31:0] r;

        rst_n   = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        sub_i   = 1'b0;
        a_drv   = '0;
        b_drv   = '0;
        lat_chk = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(vo_all), 32'd0);
        for (int g = 0; g < NI; g++) chk("rst_result", 32'(res_all[g]), 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(rdy_all), 32'((1 << NI) - 1));
        @(posedge clk);
        #1;

        // Exhaustive 4-bit (a, b, sub), back-to-back, no backpressure
        lat_chk = 1'b1;
        for (int i = 0; i < 512; i++) begin
            r       = $urandom();
            valid_i = 1'b1;
            sub_i   = i[8];
            a_drv   = {r[15:4], i[7:4]};
            b_drv   = {r[27:16], i[3:0]};
            @(posedge clk);
            #1;
        end
        drain();

        // 8-bit boundary cases
        send_one(16'h00FF, 16'h0001, 1'b0, 18'h10000);
        send_one(16'h007F, 16'h0001, 1'b0, 18'h20080);
        send_one(16'h0000, 16'h0001, 1'b1, 18'h000FF);
        send_one(16'h0005, 16'h0005, 1'b1, 18'h10000);

        // Ten ops under random backpressure (counted at the 8-bit instance)
        lat_chk = 1'b0;
        n_acc   = 0;
        guard   = 0;
        valid_i = 1'b1;
        rand_op();
        while (n_acc < 10 && guard < 500) begin
            ready_i = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = rdy_all[1];
            @(posedge clk);
            #1;
            if (acc) begin
                n_acc++;
                rand_op();
            end
            guard++;
        end
        chk("bp_ops", 32'(n_acc), 32'd10);
        drain();

        // Bubbles on alternating cycles
        lat_chk = 1'b1;
        for (int i = 0; i < 40; i++) begin
            valid_i = (i % 2 == 0);
            rand_op();
            @(posedge clk);
            #1;
        end
        drain();

        // Asynchronous reset with ops in flight
        valid_i = 1'b1;
        rand_op();
        @(posedge clk);
        #1;
        rand_op();
        @(posedge clk);
        #3;
        rst_n   = 1'b0;
        valid_i = 1'b0;
        #1;
        chk("midrst_valid", 32'(vo_all), 32'd0);
        for (int g = 0; g < NI; g++) chk("midrst_result", 32'(res_all[g]), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_valid", 32'(vo_all), 32'd0);
        chk("postrst_ready", 32'(rdy_all), 32'((1 << NI) - 1));
        repeat (20) @(posedge clk);
        #1;
        send_one(16'd3, 16'd4, 1'b0, 18'h00007);

        // Random sweep with random valid and backpressure
        lat_chk = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            valid_i = ($urandom_range(0, 99) < 85);
            ready_i = ($urandom_range(0, 99) < 70);
            rand_op();
            @(posedge clk);
            #1;
        end
        drain();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
